// File: rtl/mu0_mem_arbiter.sv
// mu0_mem_arbiter: shares the single MU0 memory port between the core and a
// debug/DMA requester. The core is stalled through cpu_en_o only when debug
// takes a cycle the core wanted. A run counter bounds how long debug can
// wait behind continuous core traffic.
//
// Handshake (debug side): dbg_req_i is raised with dbg_we_i/dbg_addr_i/
// dbg_wdata_i stable and held until dbg_ack_o; dbg_ack_o pulses for exactly
// one cycle, the cycle after the memory access, with dbg_rdata_o valid in
// that same cycle for reads. A requester may keep dbg_req_i high through the
// ack cycle to queue the next access, which is granted no earlier than the
// cycle after the ack.
module mu0_mem_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int RUN_W       = 3,
    parameter int MAX_CPU_RUN = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              cpu_rd_i,
    input  logic              cpu_wr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_en_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [CNT_W-1:0]  stall_count_o,
    output logic              err_o,
    output logic              state_o
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CPU_RUN);

    state_e             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [DATA_W-1:0]  dbg_rdata_q, dbg_rdata_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               err_q, err_d;

    logic cpu_acc;
    logic dbg_pend;
    logic run_full;
    logic grant_dbg;
    logic grant_cpu;
    logic cpu_en;

    // Grant decision: debug takes idle core cycles for free, and forces a
    // stall only once the core has won MAX_CPU_RUN times in a row.
    always_comb begin
        cpu_acc   = cpu_rd_i | cpu_wr_i;
        dbg_pend  = dbg_req_i & (state_q == IDLE);
        run_full  = (run_q >= RUN_MAX);
        grant_dbg = dbg_pend & (~cpu_acc | run_full);
        grant_cpu = cpu_acc & ~grant_dbg;
        // Core is held while in reset and whenever debug steals its access.
        cpu_en    = rst_ni & ~(dbg_pend & cpu_acc & run_full);
    end

    // Memory port mux; a simultaneous core read+write resolves to a write.
    always_comb begin
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        if (grant_dbg) begin
            mem_addr_o  = dbg_addr_i;
            mem_wdata_o = dbg_wdata_i;
            mem_rd_o    = rst_ni & ~dbg_we_i;
            mem_wr_o    = rst_ni & dbg_we_i;
        end else if (grant_cpu) begin
            mem_rd_o    = rst_ni & cpu_rd_i & ~cpu_wr_i;
            mem_wr_o    = rst_ni & cpu_wr_i;
        end
    end

    // Next-state, run counter, captured read data, statistics and error flag.
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        dbg_rdata_d = dbg_rdata_q;
        stall_d     = stall_q;
        err_d       = err_q | (cpu_rd_i & cpu_wr_i);

        case (state_q)
            IDLE: if (grant_dbg) state_d = ACK;
            ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (grant_dbg || !dbg_pend) begin
            run_d = '0;
        end else if (cpu_acc) begin
            run_d = run_q + 1'b1;
        end

        if (grant_dbg && !dbg_we_i) begin
            dbg_rdata_d = mem_rdata_i;
        end

        if (!cpu_en && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            run_q       <= '0;
            dbg_rdata_q <= '0;
            stall_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            dbg_rdata_q <= dbg_rdata_d;
            stall_q     <= stall_d;
            err_q       <= err_d;
        end
    end

    assign cpu_rdata_o   = mem_rdata_i;
    assign cpu_en_o      = cpu_en;
    assign dbg_ack_o     = (state_q == ACK);
    assign dbg_rdata_o   = dbg_rdata_q;
    assign stall_count_o = stall_q;
    assign err_o         = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Directed bench for mu0_mem_arbiter with a small combinational-read memory.
module tb_mu0_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [11:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_en;
    logic        dbg_req;
    logic        dbg_we;
    logic [11:0] dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_ack;
    logic [15:0] dbg_rdata;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] stall_count;
    logic        err;
    logic        state;

    logic [15:0] mem [4096];

    int total = 0;
    int bad   = 0;
    int ack_cnt;

    mu0_mem_arbiter dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cpu_addr_i    (cpu_addr),
        .cpu_rd_i      (cpu_rd),
        .cpu_wr_i      (cpu_wr),
        .cpu_wdata_i   (cpu_wdata),
        .cpu_rdata_o   (cpu_rdata),
        .cpu_en_o      (cpu_en),
        .dbg_req_i     (dbg_req),
        .dbg_we_i      (dbg_we),
        .dbg_addr_i    (dbg_addr),
        .dbg_wdata_i   (dbg_wdata),
        .dbg_ack_o     (dbg_ack),
        .dbg_rdata_o   (dbg_rdata),
        .mem_addr_o    (mem_addr),
        .mem_rd_o      (mem_rd),
        .mem_wr_o      (mem_wr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .stall_count_o (stall_count),
        .err_o         (err),
        .state_o       (state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, write on rising edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h123] = 16'hBEEF;
        mem[12'h050] = 16'h1234;

        rst_n     = 1'b0;
        cpu_addr  = 12'h000;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_wdata = 16'h0000;
        dbg_req   = 1'b0;
        dbg_we    = 1'b0;
        dbg_addr  = 12'h000;
        dbg_wdata = 16'h0000;

        // Reset state
        #2;
        chk("rst_cpu_en", 32'(cpu_en), 32'h0);
        chk("rst_dbg_ack", 32'(dbg_ack), 32'h0);
        chk("rst_stall", 32'(stall_count), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_dbg_rdata", 32'(dbg_rdata), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rel_cpu_en", 32'(cpu_en), 32'h1);
        chk("rel_state", 32'(state), 32'h0);

        // Idle-slot steal: core JMP cycle, debug reads 0x123
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = 12'h123;
        #1;
        chk("steal_mem_addr", 32'(mem_addr), 32'h123);
        chk("steal_mem_rd", 32'(mem_rd), 32'h1);
        chk("steal_cpu_en", 32'(cpu_en), 32'h1);
        step();
        chk("steal_ack", 32'(dbg_ack), 32'h1);
        chk("steal_rdata", 32'(dbg_rdata), 32'hBEEF);
        chk("steal_stall", 32'(stall_count), 32'h0);
        dbg_req = 1'b0;
        step();
        chk("steal_ack_low", 32'(dbg_ack), 32'h0);

        // Starvation bound: core reads every cycle, debug read of 0x050 waits
        cpu_rd   = 1'b1;
        cpu_addr = 12'h123;
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = 12'h050;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("starve_core_en", 32'(cpu_en), 32'h1);
            chk("starve_core_addr", 32'(mem_addr), 32'h123);
            chk("starve_core_ack", 32'(dbg_ack), 32'h0);
            step();
        end
        #1;
        chk("starve_dbg_en", 32'(cpu_en), 32'h0);
        chk("starve_dbg_addr", 32'(mem_addr), 32'h050);
        chk("starve_cpu_rdata", 32'(cpu_rdata), 32'h1234);
        step();
        chk("starve_ack", 32'(dbg_ack), 32'h1);
        chk("starve_rdata", 32'(dbg_rdata), 32'h1234);
        chk("starve_stall", 32'(stall_count), 32'h1);
        dbg_req = 1'b0;
        #1;
        chk("starve_ack_core_en", 32'(cpu_en), 32'h1);
        chk("starve_ack_core_addr", 32'(mem_addr), 32'h123);
        step();
        cpu_rd = 1'b0;

        // Back-to-back debug with dbg_req held through ACK
        ack_cnt  = 0;
        dbg_req  = 1'b1;
        dbg_addr = 12'h123;
        #1;
        chk("b2b_first_rd", 32'(mem_rd), 32'h1);
        step();
        if (dbg_ack) ack_cnt++;
        dbg_addr = 12'h050;
        #1;
        chk("b2b_no_grant_in_ack", 32'(mem_rd), 32'h0);
        chk("b2b_rdata1", 32'(dbg_rdata), 32'hBEEF);
        step();
        if (dbg_ack) ack_cnt++;
        #1;
        chk("b2b_second_rd", 32'(mem_rd), 32'h1);
        chk("b2b_second_addr", 32'(mem_addr), 32'h050);
        step();
        if (dbg_ack) ack_cnt++;
        chk("b2b_rdata2", 32'(dbg_rdata), 32'h1234);
        dbg_req = 1'b0;
        step();
        if (dbg_ack) ack_cnt++;
        step();
        if (dbg_ack) ack_cnt++;
        chk("b2b_ack_count", 32'(ack_cnt), 32'h2);

        // Debug write during core STA with run at the limit
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 12'h010;
        dbg_wdata = 16'h0A5A;
        cpu_rd    = 1'b1;
        cpu_addr  = 12'h123;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wr_core_en", 32'(cpu_en), 32'h1);
            step();
        end
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b1;
        cpu_addr  = 12'h020;
        cpu_wdata = 16'h7777;
        #1;
        chk("wr_dbg_en", 32'(cpu_en), 32'h0);
        chk("wr_dbg_mem_wr", 32'(mem_wr), 32'h1);
        chk("wr_dbg_addr", 32'(mem_addr), 32'h010);
        chk("wr_dbg_wdata", 32'(mem_wdata), 32'h0A5A);
        step();
        chk("wr_ack", 32'(dbg_ack), 32'h1);
        chk("wr_rdata_kept", 32'(dbg_rdata), 32'h1234);
        chk("wr_stall", 32'(stall_count), 32'h2);
        dbg_req = 1'b0;
        #1;
        chk("wr_core_en2", 32'(cpu_en), 32'h1);
        chk("wr_core_mem_wr", 32'(mem_wr), 32'h1);
        chk("wr_core_addr", 32'(mem_addr), 32'h020);
        chk("wr_core_wdata", 32'(mem_wdata), 32'h7777);
        step();
        cpu_wr = 1'b0;
        chk("wr_mem_010", 32'(mem[12'h010]), 32'h0A5A);
        chk("wr_mem_020", 32'(mem[12'h020]), 32'h7777);
        chk("wr_err_clear", 32'(err), 32'h0);

        // Error: core read and write together
        cpu_rd    = 1'b1;
        cpu_wr    = 1'b1;
        cpu_addr  = 12'h030;
        cpu_wdata = 16'h5555;
        #1;
        chk("err_mem_wr", 32'(mem_wr), 32'h1);
        chk("err_mem_rd", 32'(mem_rd), 32'h0);
        step();
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        chk("err_set", 32'(err), 32'h1);
        chk("err_mem_030", 32'(mem[12'h030]), 32'h5555);
        step();
        step();
        chk("err_sticky", 32'(err), 32'h1);

        // Reset in the middle of an ACK cycle
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = 12'h123;
        step();
        chk("mid_ack_pre", 32'(dbg_ack), 32'h1);
        rst_n   = 1'b0;
        dbg_req = 1'b0;
        #1;
        chk("mid_ack_dropped", 32'(dbg_ack), 32'h0);
        chk("mid_cpu_en", 32'(cpu_en), 32'h0);
        chk("mid_stall", 32'(stall_count), 32'h0);
        chk("mid_err", 32'(err), 32'h0);
        chk("mid_mem_rd", 32'(mem_rd), 32'h0);
        step();
        chk("mid_hold_ack", 32'(dbg_ack), 32'h0);
        chk("mid_hold_stall", 32'(stall_count), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_cpu_en", 32'(cpu_en), 32'h1);
        step();
        chk("mid_rel_ack", 32'(dbg_ack), 32'h0);
        chk("mid_rel_stall", 32'(stall_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
